systolic_controller: RTL
========================

SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand width per lane.
REQ-002 SHALL have parameter N, default 4: systolic array dimension (N rows x N columns of MAC cells).
REQ-003 SHALL have parameter K_MAX, default 16: maximum inner dimension; K_W = clog2(K_MAX+1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port start  input  1  request one matrix multiply; sampled only in IDLE.
REQ-007 SHALL have port k_len  input  K_W  inner dimension; latched when start is accepted.
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance through DONE inclusive.
REQ-009 SHALL have port done  output  1  one-cycle pulse when all accumulators hold final results.
REQ-010 SHALL have port array_clear  output  1  accumulator clear to the MAC array, active-high.
REQ-011 SHALL have port rd_en  output  N  per-lane read enable to A-row and B-column buffers.
REQ-012 SHALL have port rd_addr  output  N*K_W  per-lane k index; lane i in bits [i*K_W +: K_W].
REQ-013 SHALL have port a_rd_data  input  N*DATA_WIDTH  A-buffer read data, one-cycle read latency.
REQ-014 SHALL have port b_rd_data  input  N*DATA_WIDTH  B-buffer read data, one-cycle read latency.
REQ-015 SHALL have port a_feed  output  N*DATA_WIDTH  registered row operands to array column 0.
REQ-016 SHALL have port b_feed  output  N*DATA_WIDTH  registered column operands to array row 0.

Function
REQ-017 SHALL implement FSM IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
REQ-018 IDLE: start=1 at a rising edge SHALL latch k_len and enter CLEAR; otherwise SHALL remain in IDLE.
REQ-019 CLEAR SHALL last exactly 1 cycle with array_clear=1; array_clear SHALL be 0 in every other state.
REQ-020 FEED SHALL run a step counter t = 0 .. k_len+N-2, one value per cycle, then enter DRAIN.
REQ-021 In FEED, lane i SHALL assert rd_en[i] iff i <= t < i+k_len and SHALL drive rd_addr lane i = t-i; otherwise rd_addr lane i = 0.
REQ-022 a_feed/b_feed lane i SHALL be registered: the cycle after rd_en[i]=1 they carry a_rd_data/b_rd_data lane i; otherwise they carry 0.
REQ-023 DRAIN SHALL last exactly N+1 cycles (memory latency plus N-1 hops plus one accumulate), then enter DONE.
REQ-024 DONE SHALL last 1 cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-025 k_len=0 SHALL skip FEED (CLEAR -> DRAIN); no rd_en asserted; done still pulses.
REQ-026 k_len > K_MAX SHALL be saturated to K_MAX at latch time.
REQ-027 start while busy=1 SHALL be ignored and SHALL not alter latched k_len or the counter.
REQ-028 start held high through DONE SHALL be accepted again on the first IDLE cycle (back-to-back runs).
REQ-029 All outputs SHALL be driven from registers; outputs SHALL be stable before the array's falling-edge sampling.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, t=0, latched k_len=0, busy=0, done=0, array_clear=0, rd_en=0, rd_addr=0, a_feed=0, b_feed=0.
REQ-031 reset asserted mid-run SHALL abort with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-032 N=4, k_len=4, start at edge 0 -> array_clear high cycle 1; FEED cycles 2-8; rd_en[0] cycles 2-5, rd_en[3] cycles 5-8; done high only cycle 14; busy high cycles 1-14.
REQ-033 N=4, k_len=4, buffers hold A=identity and B[k][j]=k+4j -> a_feed lane 0 = 1,0,0,0 in cycles 3-6; full array model yields C=B at done.
REQ-034 k_len=0 -> CLEAR cycle 1, DRAIN cycles 2-6, done cycle 7; rd_en never asserted.
REQ-035 start pulsed at cycle 5 of a run with k_len=9 at that edge -> ignored; run timing and addresses unchanged.
REQ-036 reset=0 during FEED at t=3 -> all outputs 0 in the same cycle, no done; new start after release -> full correct run.
REQ-037 k_len=K_MAX+5 -> rd_en[0] asserted exactly K_MAX cycles; start held high -> second run begins the cycle after done.

Source files
------------

// File: rtl/systolic_controller.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_controller
//  Description : Sequencer for an N x N output-stationary systolic MAC array.
//                Clears the accumulators, streams skewed A-row / B-column
//                operands from the operand buffers, waits for the wavefront
//                to drain and pulses done when every accumulator is final.
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4,
   parameter int K_MAX      = 16,
   localparam int K_W       = $clog2(K_MAX + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [K_W-1:0]          k_len,
   output logic                    busy,
   output logic                    done,
   output logic                    array_clear,
   output logic [N-1:0]            rd_en,
   output logic [N*K_W-1:0]        rd_addr,
   input  logic [N*DATA_WIDTH-1:0] a_rd_data,
   input  logic [N*DATA_WIDTH-1:0] b_rd_data,
   output logic [N*DATA_WIDTH-1:0] a_feed,
   output logic [N*DATA_WIDTH-1:0] b_feed
);

   // Step counter must hold the last feed step (K_MAX+N-2) and the drain count (N).
   localparam int c_t_w = $clog2(K_MAX + N + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [c_t_w-1:0]        r_t;
   logic [c_t_w-1:0]        w_t_nxt;
   logic [K_W-1:0]          r_k;
   logic [K_W-1:0]          w_k_nxt;
   logic [K_W-1:0]          w_k_sat;

   logic                    r_busy;
   logic                    r_done;
   logic                    r_clear;
   logic [N-1:0]            r_rd_en;
   logic [N*K_W-1:0]        r_rd_addr;
   logic [N-1:0]            w_rd_en;
   logic [N*K_W-1:0]        w_rd_addr;
   logic [N*DATA_WIDTH-1:0] r_a_feed;
   logic [N*DATA_WIDTH-1:0] r_b_feed;

   // Oversized inner dimensions are clamped to what the buffers can hold.
   assign w_k_sat = (k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len;

   // State, step counter and latched inner dimension.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_t     <= '0;
         r_k     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_t     <= w_t_nxt;
         r_k     <= w_k_nxt;
      end
   end

   // Next-state, next-step and k latch; start is only looked at in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t;
      w_k_nxt     = r_k;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_CLEAR;
               w_k_nxt     = w_k_sat;
               w_t_nxt     = '0;
            end
         end
         S_CLEAR: begin
            w_t_nxt     = '0;
            w_state_nxt = (r_k == '0) ? S_DRAIN : S_FEED;
         end
         S_FEED: begin
            // Last step is t = k+N-2, i.e. t+1 == k+N-1.
            if ((r_t + c_t_w'(1)) == (c_t_w'(r_k) + c_t_w'(N - 1))) begin
               w_state_nxt = S_DRAIN;
               w_t_nxt     = '0;
            end else begin
               w_t_nxt = r_t + c_t_w'(1);
            end
         end
         S_DRAIN: begin
            // N+1 cycles: buffer latency, N-1 hops, final accumulate.
            if (r_t == c_t_w'(N)) begin
               w_state_nxt = S_DONE;
               w_t_nxt     = '0;
            end else begin
               w_t_nxt = r_t + c_t_w'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_t_nxt     = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_t_nxt     = '0;
         end
      endcase
   end

   // Lane read decode for the upcoming step: lane i is skewed by i cycles.
   always_comb begin
      w_rd_en   = '0;
      w_rd_addr = '0;
      for (int i = 0; i < N; i++) begin
         if ((w_state_nxt == S_FEED) &&
             (w_t_nxt >= c_t_w'(i)) &&
             ((w_t_nxt - c_t_w'(i)) < c_t_w'(w_k_nxt))) begin
            w_rd_en[i]               = 1'b1;
            w_rd_addr[i*K_W +: K_W]  = K_W'(w_t_nxt - c_t_w'(i));
         end
      end
   end

   // Control outputs are registered from the next-state decode so they are
   // glitch-free and settled well before the array samples on the falling edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_clear   <= 1'b0;
         r_rd_en   <= '0;
         r_rd_addr <= '0;
      end else begin
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
         r_clear   <= (w_state_nxt == S_CLEAR);
         r_rd_en   <= w_rd_en;
         r_rd_addr <= w_rd_addr;
      end
   end

   // Operand feed registers: buffer data returned for an enabled lane is
   // captured at the end of the read cycle, all other lanes inject zeros.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a_feed <= '0;
         r_b_feed <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            r_a_feed[i*DATA_WIDTH +: DATA_WIDTH] <= r_rd_en[i] ? a_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            r_b_feed[i*DATA_WIDTH +: DATA_WIDTH] <= r_rd_en[i] ? b_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign array_clear = r_clear;
   assign rd_en       = r_rd_en;
   assign rd_addr     = r_rd_addr;
   assign a_feed      = r_a_feed;
   assign b_feed      = r_b_feed;

endmodule
`default_nettype wire
